// File: rtl/timer_window_stim.sv
// timer_window_stim: drives the start (a) and stop (b) pulses of a window
// timer under test, measures how long its busy output (c) stays high and
// grades that length against the window rule T_MIN <= delay < T_MAX.
// Optional build macro TIMER_WINDOW_STIM_STATS_EN adds saturating pass/fail
// counters (pass_cnt, fail_cnt) with a synchronous clear input (stats_clr).
module timer_window_stim #(
  parameter int T_MIN    = 20,
  parameter int T_MAX    = 40,
  parameter int TOL      = 2,
  parameter int RISE_TMO = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] delay,
  input  logic             send_b,
  input  logic             c_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
`ifdef TIMER_WINDOW_STIM_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
`endif
  output logic [CNT_W-1:0] meas_len
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRE   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_GRADE  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [1:0] E_OK     = 2'd0;
  localparam logic [1:0] E_NORISE = 2'd1;
  localparam logic [1:0] E_LEN    = 2'd2;
  localparam logic [1:0] E_NOFALL = 2'd3;

  // Thresholds brought to counter width once so every compare is width-matched.
  localparam logic [CNT_W-1:0] L_TMIN = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] L_TMAX = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0] L_RISE = CNT_W'(RISE_TMO);
  localparam logic [CNT_W-1:0] L_TMO  = CNT_W'(T_MAX + TOL + RISE_TMO + 8);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   L_TOL  = (CNT_W+1)'(TOL);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_delay;
  logic             r_send_b;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_meas;
  logic             r_c_d;
  logic             r_seen;
  logic [1:0]       r_err;
  logic             r_pass;

  logic [CNT_W-1:0] w_cyc;
  logic [CNT_W-1:0] w_b_tgt;
  logic             w_seen;
  logic             w_rise_err;
  logic             w_fall;
  logic             w_tmo;
  logic [CNT_W-1:0] w_exp;
  logic [CNT_W:0]   w_m_ext;
  logic [CNT_W:0]   w_e_ext;
  logic [CNT_W:0]   w_diff;
  logic             w_len_ok;

  // Cycle count for the current RUN cycle: r_cyc is cleared in FIRE, so the
  // first RUN cycle sees 1. It saturates rather than wraps.
  always_comb begin
    w_cyc = (r_cyc == '1) ? r_cyc : r_cyc + L_ONE;
  end

  // RUN-state event decode. A zero delay is pulled up to 1 so b lands in the
  // first RUN cycle and never shares a cycle with a.
  always_comb begin
    w_b_tgt    = (r_delay == '0) ? L_ONE : r_delay;
    w_seen     = r_seen | c_in;
    w_rise_err = (w_cyc == L_RISE) && !w_seen;
    w_fall     = r_c_d && !c_in;
    w_tmo      = (w_cyc >= L_TMO);
  end

  // Expected window length and tolerance check, one bit wider than the
  // counters so the absolute difference cannot wrap.
  always_comb begin
    if (r_send_b && (r_delay >= L_TMIN) && (r_delay < L_TMAX))
      w_exp = r_delay;
    else
      w_exp = L_TMAX;
    w_m_ext  = {1'b0, r_meas};
    w_e_ext  = {1'b0, w_exp};
    w_diff   = (w_m_ext >= w_e_ext) ? (w_m_ext - w_e_ext) : (w_e_ext - w_m_ext);
    w_len_ok = (w_diff <= L_TOL);
  end

  // Transaction sequencer: IDLE -> FIRE -> RUN -> (GRADE) -> REPORT -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_delay  <= '0;
      r_send_b <= 1'b0;
      r_cyc    <= '0;
      r_meas   <= '0;
      r_c_d    <= 1'b0;
      r_seen   <= 1'b0;
      r_err    <= E_OK;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_delay  <= delay;
            r_send_b <= send_b;
            r_meas   <= '0;
            r_err    <= E_OK;
            r_pass   <= 1'b0;
            r_state  <= S_FIRE;
          end
        end
        S_FIRE: begin
          // Discard any stale c history so only post-a activity is graded.
          r_cyc   <= '0;
          r_c_d   <= 1'b0;
          r_seen  <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cyc  <= w_cyc;
          r_c_d  <= c_in;
          r_seen <= w_seen;
          if (c_in && (r_meas != '1))
            r_meas <= r_meas + L_ONE;
          if (w_rise_err) begin
            r_err   <= E_NORISE;
            r_pass  <= 1'b0;
            r_state <= S_REPORT;
          end else if (w_fall) begin
            r_state <= S_GRADE;
          end else if (w_tmo) begin
            r_err   <= E_NOFALL;
            r_pass  <= 1'b0;
            r_state <= S_REPORT;
          end
        end
        S_GRADE: begin
          // Result is settled here so pass/err_code are valid alongside done.
          if (w_len_ok) begin
            r_pass <= 1'b1;
          end else begin
            r_err  <= E_LEN;
            r_pass <= 1'b0;
          end
          r_state <= S_REPORT;
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; everything comes straight from registered state, c_in
  // never reaches an output combinationally.
  always_comb begin
    a_out    = (r_state == S_FIRE);
    b_out    = (r_state == S_RUN) && r_send_b && (w_cyc == w_b_tgt);
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_REPORT);
    pass     = r_pass;
    err_code = r_err;
    meas_len = r_meas;
  end

`ifdef TIMER_WINDOW_STIM_STATS_EN
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  // Saturating result tallies; a clear in the same cycle as done wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (stats_clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (r_state == S_REPORT) begin
      if (r_pass) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + L_ONE;
      end else begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + L_ONE;
      end
    end
  end

  // Counter outputs.
  always_comb begin
    pass_cnt = r_pass_cnt;
    fail_cnt = r_fail_cnt;
  end
`endif

endmodule
